// File: rtl/rasterix_axis_pkg.sv
// rtl/rasterix_axis_pkg.sv - shared types and helpers for the AXIS read prefetcher
package rasterix_axis_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  // Bytes covered by one data beat; used to advance the request address.
  function automatic int bytes_per_beat(input int data_width);
    return data_width / 8;
  endfunction

  // Size of the next chunk: whatever is left, capped at the crossbar burst limit.
  function automatic logic [63:0] chunk_min(input logic [63:0] left, input logic [63:0] max_beats);
    return (left < max_beats) ? left : max_beats;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// rtl/axis_sync_fifo.sv - first-word fall-through FIFO with occupancy count
module axis_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                     aclk,
  input  logic                     resetn,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage write; the head entry is read combinationally for fall-through.
  always_ff @(posedge aclk) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Pointer update; reset empties the FIFO without touching storage.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/axis_read_prefetcher.sv
// rtl/axis_read_prefetcher.sv - splits a long read into reserved chunks and streams the data out
module axis_read_prefetcher
  import rasterix_axis_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 64,
  parameter int CHUNK_BEATS = 16
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic                  s_cmd_valid,
  output logic                  s_cmd_ready,
  input  logic [ADDR_WIDTH-1:0] s_cmd_addr,
  input  logic [ADDR_WIDTH-1:0] s_cmd_beats,
  output logic                  m_avalid,
  output logic                  m_arnw,
  output logic [ADDR_WIDTH-1:0] m_aaddr,
  output logic [ADDR_WIDTH-1:0] m_abeats,
  input  logic                  m_aready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic                  s_rlast,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  output logic [DATA_WIDTH-1:0] m_xdata,
  output logic                  m_xlast,
  output logic                  m_xvalid,
  input  logic                  m_xready,
  output logic                  busy
);

  localparam int BYTES_PER_BEAT = bytes_per_beat(DATA_WIDTH);
  localparam int RES_W          = $clog2(FIFO_DEPTH) + 1;

  state_t                state;
  state_t                state_next;
  logic                  alive;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [ADDR_WIDTH-1:0] req_left;
  logic [ADDR_WIDTH-1:0] out_left;
  logic [ADDR_WIDTH-1:0] chunk;
  logic [RES_W-1:0]      reserved;
  logic [RES_W-1:0]      free_slots;
  logic [RES_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  cmd_fire;
  logic                  issue_ok;
  logic                  ack;
  logic                  push;
  logic                  pop;

  assign chunk      = ADDR_WIDTH'(chunk_min(64'(req_left), 64'(CHUNK_BEATS)));
  assign free_slots = RES_W'(FIFO_DEPTH) - reserved;
  assign issue_ok   = (state == ISSUE) && (64'(free_slots) >= 64'(chunk));
  assign ack        = (state == WAIT_ACK) && m_aready;
  assign cmd_fire   = s_cmd_valid && s_cmd_ready;
  assign push       = s_rvalid && s_rready;
  assign pop        = m_xvalid && m_xready;

  // alive holds handshakes off until the first edge after reset release.
  assign s_cmd_ready = alive && (state == IDLE) && (out_left == '0);
  assign m_avalid    = (state == WAIT_ACK);
  assign m_arnw      = 1'b0;
  assign s_rready    = alive && !fifo_full;
  assign m_xvalid    = !fifo_empty;
  assign m_xlast     = m_xvalid && (out_left == ADDR_WIDTH'(1));
  // Buffered beats always belong to the current command, so they imply busy too.
  assign busy        = (state != IDLE) || (out_left != '0) || (fifo_count != '0);

  // State register.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: a chunk goes out only once its whole footprint fits in the FIFO.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (cmd_fire && (s_cmd_beats != '0)) state_next = ISSUE;
      ISSUE:    if (issue_ok) state_next = WAIT_ACK;
      WAIT_ACK: if (m_aready) state_next = (req_left == m_abeats) ? DRAIN : ISSUE;
      DRAIN:    if (out_left == '0) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Request bookkeeping, held request payload and FIFO slot reservation.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      alive    <= 1'b0;
      req_addr <= '0;
      req_left <= '0;
      out_left <= '0;
      reserved <= '0;
      m_aaddr  <= '0;
      m_abeats <= '0;
    end else begin
      alive <= 1'b1;
      if (cmd_fire) begin
        req_addr <= s_cmd_addr;
        req_left <= s_cmd_beats;
      end else if (ack) begin
        req_addr <= req_addr + m_abeats * ADDR_WIDTH'(BYTES_PER_BEAT);
        req_left <= req_left - m_abeats;
      end
      if (issue_ok) begin
        m_aaddr  <= req_addr;
        m_abeats <= chunk;
      end
      if (cmd_fire) begin
        out_left <= s_cmd_beats;
      end else if (pop) begin
        out_left <= out_left - ADDR_WIDTH'(1);
      end
      reserved <= reserved + (ack ? RES_W'(m_abeats) : RES_W'(0)) - RES_W'(pop);
    end
  end

  axis_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk    (aclk),
    .resetn  (resetn),
    .wr_en   (push),
    .wr_data (s_rdata),
    .rd_en   (pop),
    .rd_data (m_xdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Chunk boundaries come from the beat counts; the crossbar's last flag is redundant.
  logic unused_rlast;
  assign unused_rlast = s_rlast;

endmodule

// File: tb/tb_axis_read_prefetcher.sv
// tb/tb_axis_read_prefetcher.sv - directed scoreboard bench for axis_read_prefetcher
module tb_axis_read_prefetcher;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 64;
  localparam int CHUNK = 16;

  logic          aclk = 1'b0;
  logic          resetn = 1'b0;
  logic          s_cmd_valid = 1'b0;
  logic          s_cmd_ready;
  logic [AW-1:0] s_cmd_addr = '0;
  logic [AW-1:0] s_cmd_beats = '0;
  logic          m_avalid;
  logic          m_arnw;
  logic [AW-1:0] m_aaddr;
  logic [AW-1:0] m_abeats;
  logic          m_aready = 1'b0;
  logic [DW-1:0] s_rdata = '0;
  logic          s_rlast = 1'b0;
  logic          s_rvalid = 1'b0;
  logic          s_rready;
  logic [DW-1:0] m_xdata;
  logic          m_xlast;
  logic          m_xvalid;
  logic          m_xready = 1'b0;
  logic          busy;

  axis_read_prefetcher #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .FIFO_DEPTH (DEPTH), .CHUNK_BEATS (CHUNK)
  ) dut (
    .aclk (aclk), .resetn (resetn),
    .s_cmd_valid (s_cmd_valid), .s_cmd_ready (s_cmd_ready),
    .s_cmd_addr (s_cmd_addr), .s_cmd_beats (s_cmd_beats),
    .m_avalid (m_avalid), .m_arnw (m_arnw), .m_aaddr (m_aaddr), .m_abeats (m_abeats),
    .m_aready (m_aready),
    .s_rdata (s_rdata), .s_rlast (s_rlast), .s_rvalid (s_rvalid), .s_rready (s_rready),
    .m_xdata (m_xdata), .m_xlast (m_xlast), .m_xvalid (m_xvalid), .m_xready (m_xready),
    .busy (busy)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [31:0] a; logic [31:0] b; } req_t;
  typedef struct { logic [31:0] d; logic l; } beat_t;

  req_t        exp_req[$];
  beat_t       exp_out[$];
  logic [31:0] rq[$];
  logic        rl_q[$];

  int          tests = 0;
  int          fails = 0;
  int          req_count = 0;
  int          out_count = 0;
  int          pop_budget = 0;
  int          ack_delay = 0;
  int          av_cnt = 0;
  logic        stable_ok = 1'b1;
  logic [31:0] held_a = '0;
  logic [31:0] held_b = '0;
  logic [31:0] last_ack_addr = '0;
  logic        cmd_req = 1'b0;
  logic        cmd_acc = 1'b0;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_n = '0;
  logic        seen_activity = 1'b0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h2468ACE1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected chunk requests and output beats for an accepted command.
  task automatic model_cmd(input logic [31:0] a0, input logic [31:0] n);
    logic [31:0] a;
    int unsigned left;
    int unsigned c;
    for (int unsigned i = 0; i < n; i++) begin
      exp_out.push_back(beat_t'{data_of(a0 + i * 4), (i == n - 1)});
    end
    a = a0;
    left = n;
    while (left > 0) begin
      c = (left < CHUNK) ? left : CHUNK;
      exp_req.push_back(req_t'{a, c});
      a = a + c * 4;
      left = left - c;
    end
  endtask

  // One cycle: drive inputs at negedge, then score the handshakes of the coming posedge.
  task automatic step();
    beat_t       b;
    req_t        r;
    logic        have;
    logic [31:0] tmp_a;
    logic        tmp_l;
    @(negedge aclk);
    s_cmd_valid = cmd_req;
    s_cmd_addr  = cmd_a;
    s_cmd_beats = cmd_n;
    if (m_avalid) begin
      if (av_cnt == 0) begin
        held_a = m_aaddr;
        held_b = m_abeats;
        stable_ok = 1'b1;
      end else if (m_aaddr !== held_a || m_abeats !== held_b) begin
        stable_ok = 1'b0;
      end
      m_aready = (av_cnt == ack_delay);
      av_cnt++;
    end else begin
      m_aready = 1'b0;
      av_cnt = 0;
    end
    if (rq.size() > 0) begin
      s_rvalid = 1'b1;
      s_rdata  = data_of(rq[0]);
      s_rlast  = rl_q[0];
    end else begin
      s_rvalid = 1'b0;
      s_rdata  = '0;
      s_rlast  = 1'b0;
    end
    m_xready = (pop_budget > 0);
    #1;
    if (m_avalid || m_xvalid || busy) seen_activity = 1'b1;
    if (s_cmd_valid && s_cmd_ready) begin
      cmd_req = 1'b0;
      cmd_acc = 1'b1;
      model_cmd(s_cmd_addr, s_cmd_beats);
    end
    if (s_rvalid && s_rready) begin
      tmp_a = rq.pop_front();
      tmp_l = rl_q.pop_front();
    end
    if (m_avalid && m_aready) begin
      have = (exp_req.size() > 0);
      check("req_expected", have, 1);
      if (have) begin
        r = exp_req.pop_front();
        check("req_addr", m_aaddr, r.a);
        check("req_beats", m_abeats, r.b);
      end
      check("req_payload_stable", stable_ok, 1);
      check("req_hold_cycles", av_cnt, ack_delay + 1);
      for (int i = 0; i < int'(m_abeats) && i < 256; i++) begin
        rq.push_back(m_aaddr + 32'(i) * 4);
        rl_q.push_back(i == int'(m_abeats) - 1);
      end
      last_ack_addr = m_aaddr;
      req_count++;
    end
    if (m_xvalid && m_xready) begin
      have = (exp_out.size() > 0);
      check("out_expected", have, 1);
      if (have) begin
        b = exp_out.pop_front();
        check("out_data", m_xdata, b.d);
        check("out_last", m_xlast, b.l);
      end
      pop_budget--;
      out_count++;
    end
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [31:0] n);
    int k;
    cmd_a = a;
    cmd_n = n;
    cmd_req = 1'b1;
    cmd_acc = 1'b0;
    k = 0;
    while (!cmd_acc && k < 100) begin
      step();
      k++;
    end
    check("cmd_handshake", cmd_acc, 1);
  endtask

  task automatic run_until_done(input int budget);
    int k;
    logic done;
    k = 0;
    done = 1'b0;
    while (!done && k < budget) begin
      step();
      k++;
      done = (exp_req.size() == 0) && (exp_out.size() == 0) && (rq.size() == 0);
    end
    check("run_complete", done, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"}, s_cmd_ready, 0);
    check({tag, "_avalid"}, m_avalid, 0);
    check({tag, "_arnw"}, m_arnw, 0);
    check({tag, "_aaddr"}, m_aaddr, 0);
    check({tag, "_abeats"}, m_abeats, 0);
    check({tag, "_rready"}, s_rready, 0);
    check({tag, "_xvalid"}, m_xvalid, 0);
    check({tag, "_xlast"}, m_xlast, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge aclk);
    #1;
    check_all_zero("reset");
    @(negedge aclk);
    resetn = 1'b1;
    step();
    check("idle_cmd_ready", s_cmd_ready, 1);

    // Three chunks with the consumer always ready.
    ack_delay = 0; pop_budget = 1000; req_count = 0; out_count = 0;
    send_cmd(32'h0000_1000, 40);
    run_until_done(1000);
    repeat (3) step();
    check("t1_req_count", req_count, 3);
    check("t1_out_count", out_count, 40);
    check("t1_busy", busy, 0);
    check("t1_cmd_ready", s_cmd_ready, 1);

    // Consumer stalled: reservation caps outstanding requests at the FIFO depth.
    pop_budget = 0; req_count = 0; out_count = 0;
    send_cmd(32'h0000_1000, 100);
    repeat (300) step();
    check("t2_req_withheld", req_count, 4);
    check("t2_avalid_low", m_avalid, 0);
    check("t2_busy", busy, 1);
    pop_budget = 16;
    repeat (80) step();
    check("t2_fifth_req", req_count, 5);
    check("t2_fifth_addr", last_ack_addr, 32'h0000_1100);
    pop_budget = 1000;
    run_until_done(2000);
    repeat (3) step();
    check("t2_out_count", out_count, 100);
    check("t2_busy_end", busy, 0);

    // Slow address acceptance: payload held for the whole wait.
    ack_delay = 7; req_count = 0;
    send_cmd(32'h0000_3000, 16);
    run_until_done(500);
    repeat (2) step();
    check("t3_req_count", req_count, 1);
    ack_delay = 0;

    // Zero-length command is consumed silently.
    seen_activity = 1'b0; req_count = 0;
    send_cmd(32'h0000_4000, 0);
    repeat (20) step();
    check("t4_no_activity", seen_activity, 0);
    check("t4_no_req", req_count, 0);
    check("t4_cmd_ready", s_cmd_ready, 1);

    // Address wraps past the top of the space.
    req_count = 0;
    send_cmd(32'hFFFF_FFC0, 32);
    run_until_done(500);
    repeat (2) step();
    check("t5_req_count", req_count, 2);
    check("t5_wrap_addr", last_ack_addr, 32'h0000_0000);

    // Reset while draining with ten beats buffered.
    pop_budget = 0;
    send_cmd(32'h0000_5000, 10);
    repeat (60) step();
    check("t6_buffered_valid", m_xvalid, 1);
    check("t6_buffered_busy", busy, 1);
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_req.delete();
    exp_out.delete();
    rq.delete();
    rl_q.delete();
    cmd_req = 1'b0;
    m_aready = 1'b0;
    s_rvalid = 1'b0;
    m_xready = 1'b0;
    av_cnt = 0;
    repeat (2) @(negedge aclk);
    resetn = 1'b1;
    pop_budget = 1000; out_count = 0; req_count = 0;
    send_cmd(32'h0000_2000, 5);
    run_until_done(500);
    repeat (5) step();
    check("t6_out_count", out_count, 5);
    check("t6_req_count", req_count, 1);
    check("t6_busy_end", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_read_prefetcher.md
Name: axis_read_prefetcher

Overview:
- Per-port read client placed directly upstream/downstream of the AXIS-to-AXI crossbar port.
- Takes one long read command (start address, total beats) and splits it into chunked address requests (`avalid/arnw/aaddr/abeats`) on one crossbar port.
- Buffers the returned read stream in a local FIFO and presents it as a single AXIS stream with `last` on the final beat of the whole command.
- Issues a chunk only when FIFO space for the whole chunk is reserved, so the crossbar read port is never back-pressured and never stalls other ports.

Parameters:
- DATA_WIDTH, 32, width of read data beats.
- ADDR_WIDTH, 32, width of address and beat-count fields.
- FIFO_DEPTH, 64, buffer depth in beats; power of two, >= CHUNK_BEATS.
- CHUNK_BEATS, 16, maximum beats per crossbar address request; 1..256.

Ports:
- aclk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- s_cmd_valid  in  1  read command valid
- s_cmd_ready  out  1  command accepted
- s_cmd_addr  in  ADDR_WIDTH  byte start address, beat aligned
- s_cmd_beats  in  ADDR_WIDTH  total beats to read
- m_avalid  out  1  address request valid to crossbar
- m_arnw  out  1  constant 0 (read)
- m_aaddr  out  ADDR_WIDTH  chunk byte address
- m_abeats  out  ADDR_WIDTH  chunk beat count
- m_aready  in  1  crossbar accept pulse
- s_rdata  in  DATA_WIDTH  read data from crossbar
- s_rlast  in  1  chunk last from crossbar
- s_rvalid  in  1  read data valid
- s_rready  out  1  read data ready
- m_xdata  out  DATA_WIDTH  buffered output data
- m_xlast  out  1  final beat of the command
- m_xvalid  out  1  output valid
- m_xready  in  1  output ready
- busy  out  1  command in progress (requests pending or data undrained)

Behaviour:
- Reset (async, resetn=0): state IDLE. All counters and FIFO pointers are 0. Outputs while in reset: s_cmd_ready=0, m_avalid=0, m_arnw=0, m_aaddr=0, m_abeats=0, s_rready=0, m_xvalid=0, m_xlast=0, busy=0. Deassertion takes effect on the next aclk edge.
- Registers:
  - req_addr, req_left: beats still to request.
  - out_left: beats still to emit.
  - reserved: FIFO slots reserved, range 0..FIFO_DEPTH.
- s_cmd_ready=1 only in IDLE with out_left==0.
- On command handshake:
  - Load req_addr=s_cmd_addr, req_left=out_left=s_cmd_beats.
  - beats==0: stay IDLE, busy stays 0, no request, no output.
- States:
  - IDLE: on accepted command with beats>0, go to ISSUE.
  - ISSUE: chunk = min(req_left, CHUNK_BEATS). When FIFO_DEPTH-reserved >= chunk, register m_aaddr=req_addr and m_abeats=chunk, assert m_avalid, go to WAIT_ACK.
  - WAIT_ACK: hold m_avalid and payload stable until m_aready=1; on that cycle drop m_avalid.
    - Then reserved += chunk, req_addr += chunk*(DATA_WIDTH/8) (wraps modulo 2^ADDR_WIDTH), req_left -= chunk.
    - If req_left (new) == 0, go to DRAIN; else go to ISSUE.
  - DRAIN: when out_left==0, go to IDLE.
- m_aready is a one-cycle pulse that may arrive any number of cycles after m_avalid.
- s_rready = (FIFO not full). Reservation guarantees not-full for accepted chunks. Each s_rvalid&&s_rready pushes one beat.
- s_rlast is not used for counting; beat counts are authoritative.
- Output side:
  - m_xvalid = FIFO not empty. Standard AXIS: data and last stable while valid && !ready.
  - Each m_xvalid&&m_xready pops one beat, decrements out_left, and decrements reserved.
- m_xlast = m_xvalid && (out_left==1).
- Simultaneous reserve (+chunk) and pop (-1) in one cycle: reserved += chunk-1.
- Simultaneous push and pop: FIFO count unchanged.
- FIFO latency: a beat pushed at edge N is visible on m_x* after edge N (first-word fall-through, 0 extra cycles).
- busy = state!=IDLE || out_left!=0.
- Reset mid-transfer discards the FIFO and all counters. The crossbar shares resetn, so no orphan transfer remains.

Decomposition:
- Shared package `rasterix_axis_pkg`: state enum (IDLE, ISSUE, WAIT_ACK, DRAIN), localparam BYTES_PER_BEAT = DATA_WIDTH/8, chunk/min helper function.
- Sub-module `axis_sync_fifo`: first-word fall-through FIFO with DEPTH and WIDTH parameters, async active-low reset, full/empty/count outputs. Instantiated with WIDTH=DATA_WIDTH.

Test Plan:
- Command addr=0x1000, beats=40, CHUNK=16, DEPTH=64, m_xready=1 -> requests (0x1000,16), (0x1040,16), (0x1080,8); 40 output beats in order; m_xlast only on beat 40; then IDLE and busy=0.
- m_xready=0 throughout, beats=100 -> exactly 4 requests issued (64 reserved), 5th withheld. Release 16 beats -> 5th request (0x1100,16) issued.
- m_aready delayed 7 cycles -> m_avalid, m_aaddr and m_abeats held constant all 7 cycles; exactly one request counted.
- beats=0 -> s_cmd_ready handshake completes; no m_avalid, no m_xvalid, busy stays 0.
- Address wrap: addr=0xFFFFFFC0, beats=32 -> second chunk address 0x00000000.
- resetn asserted mid-DRAIN with 10 beats buffered -> all outputs 0 immediately (async). After release, a new command is accepted; no stale beats are emitted.
